async_fifo_write_controller: RTL
================================

Name: async_fifo_write_controller

Overview:
Write-side controller for a dual-clock FIFO. It owns the Gray-coded write pointer and accepts writes with a valid/ready handshake. It drives write enable and address to the external storage RAM, and exports the Gray write pointer to the read domain. It also synchronises the read domain's Gray read pointer, from which it computes full, almost-full and fill level for the write domain.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
SYNC_STAGES, 2, number of flip-flop stages synchronising the incoming read pointer; minimum 2.
ALMOST_FULL_THRESHOLD, DEPTH-1, almost_full asserts when level >= this value; legal range 1..DEPTH.
ADDR_WIDTH, CLOG2(DEPTH), width of the storage address.
PTR_WIDTH, ADDR_WIDTH+1, pointer width including the wrap bit.

Ports:
clock  input  1  write-domain clock
resetn  input  1  asynchronous active-low reset
write_valid  input  1  requester has data to write
write_ready  output  1  controller can accept a write; equals !full
memory_write_enable  output  1  RAM write strobe; equals write_valid && write_ready
memory_write_address  output  ADDR_WIDTH  RAM address; equals the low ADDR_WIDTH bits of the binary write pointer
write_pointer_gray  output  PTR_WIDTH  registered Gray write pointer, sent to the read domain
read_pointer_gray  input  PTR_WIDTH  Gray read pointer from the read domain, asynchronous to clock
full  output  1  FIFO full
almost_full  output  1  level >= ALMOST_FULL_THRESHOLD
level  output  PTR_WIDTH  entries occupied, as seen from the write domain (0..DEPTH)

Behaviour:
- Reset is resetn, asynchronous and active-low, on clock clock.
- Values in reset:
  - write pointer, binary and Gray, = 0
  - every synchroniser stage = 0
  - full = 0, almost_full = 0 (unless ALMOST_FULL_THRESHOLD check against 0 says otherwise; illegal), level = 0
  - write_ready = 1
  - memory_write_enable = 0 while write_valid = 0
- Write pointer:
  - PTR_WIDTH-bit wrapping counter with range 2*DEPTH, increment only.
  - It holds a binary value and a registered Gray value that change in the same cycle.
- Accepting a write:
  - A write is accepted in any cycle where write_valid=1 and write_ready=1.
  - memory_write_enable is combinational, in the same cycle.
  - The pointer advances at the next rising clock edge.
  - Zero-cycle latency from request to RAM strobe.
- Requester and storage rules:
  - A write attempted while full has no effect: no strobe and no pointer change.
  - The requester may drop write_valid without a handshake.
  - The data path does not pass through this block; the RAM captures data when the strobe is high.
- Wrap-around: after 2*DEPTH writes the pointer returns to binary 0 / Gray 0, and the address wraps every DEPTH writes.
- Read pointer synchroniser:
  - read_pointer_gray passes through SYNC_STAGES flip-flops, giving read_gray_sync.
  - Nothing else samples read_pointer_gray directly.
- Full:
  - full = (write_pointer_gray == {~read_gray_sync[PTR_WIDTH-1:PTR_WIDTH-2], read_gray_sync[PTR_WIDTH-3:0]}).
  - For DEPTH=2, PTR_WIDTH=2 and both bits are inverted.
  - full is combinational from registers only, so it is glitch-free in the write domain.
- Level:
  - read_gray_sync is converted to binary, giving read_binary_sync.
  - level = write_binary - read_binary_sync, modulo 2^PTR_WIDTH; the result is always in 0..DEPTH.
  - almost_full is combinational from level.
- Pessimism:
  - full and level are conservative: a read becomes visible only SYNC_STAGES clock cycles after read_pointer_gray changes.
  - A write at the same edge updates level immediately on the next cycle.
- Simultaneous events:
  - A write accepted in the same cycle as a read pointer update gives a next-cycle level of old level + 1.
  - The read update appears after synchroniser latency.
- Gray output stability: write_pointer_gray changes at most one bit per clock edge, and it never glitches because it comes straight from a flip-flop.
- Reset during operation:
  - All state clears immediately.
  - The read domain must also be reset; resetting only one side is outside this block's scope and has no defined behaviour.

Decomposition:
- Shared header holds:
  - the CLOG2 and IS_POW2 macros
  - a PTR_WIDTH derivation macro
  - the full-compare inverted-MSB mask constant
- Reuse the existing gray_wrapping_counter, with RANGE=2*DEPTH and decrement tied to 0, for the write pointer.
- New sub-module gray_to_binary, combinational and parameterised on WIDTH; it is reused later by the read-side controller.
- The synchroniser is an inline shift register in this block.

Test Plan:
- DEPTH=4, SYNC_STAGES=2, read_pointer_gray held at 0; 4 writes in 4 cycles:
  - memory_write_address = 0,1,2,3
  - after the 4th write, full=1, write_ready=0, level=4
  - a 5th write_valid gives memory_write_enable=0 and the pointer stays at binary 4 / Gray 110.
- While full, set read_pointer_gray=001 (one read done):
  - full stays 1 for exactly 2 cycles, then falls
  - level=3, write_ready=1.
- Wrap-around, keeping the FIFO below full by advancing read_pointer_gray in step:
  - 8 accepted writes give write_pointer_gray sequence 001,011,010,110,111,101,100,000
  - each step changes exactly 1 bit
  - the address sequence is 0,1,2,3,0,1,2,3.
- ALMOST_FULL_THRESHOLD=3, read_pointer_gray held at 0, starting empty:
  - almost_full=0 at level 2
  - almost_full=1 the cycle after the 3rd write
  - almost_full=0 again 2 cycles after read_pointer_gray advances to 001.
- Simultaneous events: at level 2, a write is accepted at the same edge as read_pointer_gray changes:
  - next cycle level=3
  - 2 cycles later level=2.
- resetn asserted while level=3:
  - level=0, full=0, write_pointer_gray=0 and write_ready=1 with no clock edge
  - after release, the first write goes to address 0.

Source files
------------

// File: rtl/async_fifo_write_controller_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: pointer sizing and the
// constant used to build the "full" compare from a Gray read pointer.
package async_fifo_write_controller_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic isPow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int unsigned ptrWidth(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    // Full means the Gray pointers differ only in their two top bits.
    function automatic int unsigned fullMaskValue(input int unsigned width);
        return 32'd3 << (width - 2);
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter, shared by both FIFO controllers.
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] binary_o
);

    // Each binary bit is the parity of the Gray bits at and above it.
    always_comb begin
        binary_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            binary_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/gray_wrapping_counter.sv
// Wrapping up/down counter that keeps a binary value and a registered Gray
// copy which always change on the same clock edge.
module gray_wrapping_counter #(
    parameter int RANGE = 16,
    parameter int WIDTH = $clog2(RANGE)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             increment_i,
    input  logic             decrement_i,
    output logic [WIDTH-1:0] binary_o,
    output logic [WIDTH-1:0] gray_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(RANGE - 1);

    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] gray_q, gray_d;

    always_comb begin
        binary_d = binary_q;
        if (increment_i && !decrement_i) begin
            binary_d = (binary_q == LAST) ? '0 : binary_q + 1'b1;
        end else if (decrement_i && !increment_i) begin
            binary_d = (binary_q == '0) ? LAST : binary_q - 1'b1;
        end
        gray_d = binary_d ^ (binary_d >> 1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            binary_q <= '0;
            gray_q   <= '0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
        end
    end

    assign binary_o = binary_q;
    assign gray_o   = gray_q;

endmodule

// File: rtl/async_fifo_write_controller.sv
// Write-side controller of a dual-clock FIFO: owns the Gray write pointer,
// strobes the RAM and derives full / almost-full / level from the read pointer.
module async_fifo_write_controller
    import async_fifo_write_controller_pkg::*;
#(
    parameter int DEPTH                 = 8,
    parameter int SYNC_STAGES           = 2,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1,
    parameter int ADDR_WIDTH            = $clog2(DEPTH),
    parameter int PTR_WIDTH             = ADDR_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  write_valid,
    output logic                  write_ready,
    output logic                  memory_write_enable,
    output logic [ADDR_WIDTH-1:0] memory_write_address,
    output logic [PTR_WIDTH-1:0]  write_pointer_gray,
    input  logic [PTR_WIDTH-1:0]  read_pointer_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [PTR_WIDTH-1:0]  level
);

    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(fullMaskValue(PTR_WIDTH));
    localparam logic [PTR_WIDTH-1:0] AF_LEVEL  = PTR_WIDTH'(ALMOST_FULL_THRESHOLD);

    logic [PTR_WIDTH-1:0] writeBinary;
    logic [PTR_WIDTH-1:0] writeGray;
    logic [PTR_WIDTH-1:0] readSync_q [SYNC_STAGES];
    logic [PTR_WIDTH-1:0] readGraySync;
    logic [PTR_WIDTH-1:0] readBinarySync;

    gray_wrapping_counter #(
        .RANGE (2 * DEPTH),
        .WIDTH (PTR_WIDTH)
    ) writePointer (
        .clock       (clock),
        .resetn      (resetn),
        .increment_i (memory_write_enable),
        .decrement_i (1'b0),
        .binary_o    (writeBinary),
        .gray_o      (writeGray)
    );

    // Only the first stage ever sees the asynchronous read pointer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                readSync_q[i] <= '0;
            end
        end else begin
            readSync_q[0] <= read_pointer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                readSync_q[i] <= readSync_q[i-1];
            end
        end
    end

    assign readGraySync = readSync_q[SYNC_STAGES-1];

    gray_to_binary #(
        .WIDTH (PTR_WIDTH)
    ) readConvert (
        .gray_i   (readGraySync),
        .binary_o (readBinarySync)
    );

    assign full                 = (writeGray == (readGraySync ^ FULL_MASK));
    assign write_ready          = !full;
    assign memory_write_enable  = write_valid && write_ready;
    assign memory_write_address = writeBinary[ADDR_WIDTH-1:0];
    assign write_pointer_gray   = writeGray;
    assign level                = writeBinary - readBinarySync;
    assign almost_full          = (level >= AF_LEVEL);

endmodule
